// File: rtl/as5_event_logger_if.sv
// ----------------------------------------------------------------------------
// as5_event_logger_if
// Record drain channel of the event logger (valid/ready).
//   out_valid : head record is available          (logger -> consumer)
//   out_ready : consumer accepts head this cycle   (consumer -> logger)
//   out_data  : {ts[TS_W-1:0], snap[5:0], chg[5:0]} (logger -> consumer)
// ----------------------------------------------------------------------------
interface as5_event_logger_if #(
    parameter int TS_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [TS_W+11:0]  out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/as5_event_logger.sv
// ----------------------------------------------------------------------------
// as5_event_logger
// Samples {z,y,x,w} every clock, detects changes between consecutive samples
// and queues a timestamped record per change in a small FIFO drained over a
// valid/ready channel.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   w, x, y, z : upstream signals (z is 3 bits)
//   out_if     : record channel (master side), see as5_event_logger_if
//   overflow   : sticky, set when an event was dropped on a full FIFO
//   drop_cnt   : saturating dropped-event count
//
// Build option: define AS5_DROP_COUNT_EN to implement drop_cnt; otherwise it
// is tied to zero. overflow is present in both builds.
// ----------------------------------------------------------------------------
module as5_event_logger #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w,
    input  logic                  x,
    input  logic                  y,
    input  logic [2:0]            z,
    as5_event_logger_if.master    out_if,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);
    localparam int AW     = $clog2(DEPTH);
    localparam int RW     = TS_W + 12;
    localparam int STAGES = 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [5:0]      s, p;
    logic [STAGES:0] vld_pipe;   // [0]: s loaded, [STAGES]: s/p comparison valid
    logic [TS_W-1:0] ts;

    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;

    logic [5:0]      chg;
    logic            push_req, pop, push_ok, drop;

    // Change detect is gated until p holds a real sample, so the reset
    // baseline never produces an event.
    always_comb begin
        chg      = vld_pipe[STAGES] ? (s ^ p) : 6'd0;
        push_req = |chg;
        pop      = out_if.out_valid & out_if.out_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push_ok  = push_req & ((count != FULL) | pop);
        drop     = push_req & ~push_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= '0;
            p        <= '0;
            vld_pipe <= '0;
            ts       <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            s        <= {z, y, x, w};
            p        <= s;
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            ts       <= ts + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= {ts, s, chg};
    end

    assign out_if.out_valid = (count != '0);
    assign out_if.out_data  = out_if.out_valid ? mem[rd_ptr] : '0;

`ifdef AS5_DROP_COUNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst)                          drop_q <= '0;
        else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: doc/as5_event_logger.md
Name: as5_event_logger

Overview:
- Downstream consumer of the delayed-assignment stimulus stage, which drives three 1-bit signals w, x, y and a 3-bit bus z.
- Samples those four signals on a single clock and detects any change between consecutive samples.
- On each change, builds a timestamped event record and buffers it in a small FIFO.
- Records are drained over a valid/ready interface to a checker or monitor.

Parameters:
- TS_W, 8, width of the free-running timestamp counter (wraps modulo 2^TS_W).
- DEPTH, 4, FIFO depth in records; must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- w  input  1  upstream signal
- x  input  1  upstream signal
- y  input  1  upstream signal
- z  input  3  upstream bus
- out_valid  output  1  head record is available
- out_ready  input  1  consumer accepts the head record this cycle
- out_data  output  TS_W+12  record = {ts[TS_W-1:0], snap[5:0], chg[5:0]}; snap = {z,y,x,w}, chg = snap XOR previous snap
- overflow  output  1  sticky: at least one event was dropped
- drop_cnt  output  8  dropped-event count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset state, all cleared:
  - sample registers s and p;
  - primed flag;
  - ts;
  - FIFO read/write pointers and count;
  - overflow and drop_cnt.
- During reset and on the cycle after reset: out_valid=0, out_data=0, overflow=0, drop_cnt=0.
- Reset mid-operation discards all buffered records with no flush.
- Sampling pipeline, each edge after reset:
  - s <= {z,y,x,w};
  - p <= s;
  - primed <= 1 one edge after s is first loaded.
  - Change detect: chg = s XOR p, qualified by primed. No event is generated from the reset baseline.
- Timestamp: ts increments every non-reset edge and wraps from 2^TS_W-1 to 0. A record carries the ts value of the cycle in which the change is detected (the combinational value before the increment).
- Latency:
  - An input change present before edge k is captured in s at edge k.
  - It is pushed at edge k+1.
  - out_valid rises after edge k+1 if the FIFO was empty.
  - There is no fall-through path from input to out_data.
- FIFO:
  - out_data is always the head entry, stable while out_valid=1 and out_ready=0.
  - A pop occurs when out_valid AND out_ready at an edge.
  - Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop with count 0: the push is stored, out_valid=0 this cycle, and the record appears next cycle.
  - Simultaneous push and pop at other counts: count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - out_valid = (count != 0).
- Overflow: a push rejected when full drops the event and sets overflow=1, which holds until rst.
- Multiple bits changing in one cycle produce ONE record with multiple chg bits set.
- A signal that toggles and returns between two samples is not seen; this is documented, not an error.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: AS5_DROP_COUNT_EN.
- Defined: drop_cnt increments on every dropped event and saturates at 255; it is cleared only by rst.
- Undefined: drop_cnt is constant 0 and its counter logic is absent. overflow behaves identically in both builds.

Test Plan:
- Reset baseline: hold rst 3 cycles with w=x=y=0, z=0; release; hold inputs 10 cycles -> out_valid stays 0, overflow=0.
- Single change: after the baseline, set w=1 at cycle 20 (ts=20 at detection) -> out_valid rises 2 edges later; out_data ts=20 (expected detection value; confirm against the ts-at-detection rule above), snap=6'b000001, chg=6'b000001.
- Multi-bit change in one cycle: baseline w=1, z=3'b000; then drive b=1 (x), c=0 (y), d=3'b101 (z) simultaneously -> one record with snap=6'b101011, chg=6'b101010.
- Full/overflow, out_ready=0, DEPTH=4:
  - Toggle w every cycle for 6 changes -> first 4 records are kept, overflow=1.
  - drop_cnt=2 with AS5_DROP_COUNT_EN, 0 without.
  - Then assert out_ready -> 4 records drain in order with increasing ts.
- Simultaneous push and pop at full: FIFO full, out_ready=1, and a new change in the same cycle -> the change is accepted, count stays 4, overflow is not set.
- Timestamp wrap and mid-operation reset, TS_W=8:
  - Change at ts=255, then another at ts=0 -> records show ts 255 then 0.
  - Pulse rst with 2 records buffered -> out_valid=0 next cycle and no stale record appears.
